// File: rtl/alu_shift_stage_if.sv
// alu_shift_stage_if: request/result bundle between EX-stage control and the shift stage.
//   start      - request strobe, honoured only when the stage is idle or completing
//   alu_result - operand word from the ALU
//   shift_op   - 00 SLL, 01 SRL, 10 SRA, 11 ROL
//   shamt      - shift amount, 0..2**SHAMT_W-1
//   busy       - stage is shifting
//   done       - one-cycle completion pulse
//   shift_out  - held result word
//   zero       - shift_out == 0
//   carry_out  - last bit shifted/rotated out (0 for a zero shift)
// master: EX-stage control side. slave: the shift stage itself.
interface alu_shift_stage_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
);
  logic               start;
  logic [WIDTH-1:0]   alu_result;
  logic [1:0]         shift_op;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   shift_out;
  logic               zero;
  logic               carry_out;

  modport master (
    output start, alu_result, shift_op, shamt,
    input  busy, done, shift_out, zero, carry_out
  );

  modport slave (
    input  start, alu_result, shift_op, shamt,
    output busy, done, shift_out, zero, carry_out
  );
endinterface

// File: rtl/alu_shift_stage.sv
// alu_shift_stage: multi-cycle shifter behind the ALU, one bit position per clock.
// Supports SLL/SRL/SRA/ROL. A request captured at edge k with shamt N completes with done
// high in the cycle after edge k+N (N=0 completes right after edge k).
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset; discards any in-flight shift
//   bus - alu_shift_stage_if slave modport (start/operand in, busy/done/result out)
module alu_shift_stage #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input logic               clk,
  input logic               rst,
  alu_shift_stage_if.slave  bus
);

  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b01;
  localparam logic [1:0] OpSra = 2'b10;
  localparam logic [1:0] OpRol = 2'b11;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   work_q;
  logic [1:0]         op_q;
  logic [SHAMT_W-1:0] count_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   shift_out_q;
  logic               carry_q;

  // One-position step of the working operand and the bit that leaves it.
  logic [WIDTH-1:0]   step_w;
  logic               step_bit;

  always_comb begin
    step_w   = work_q;
    step_bit = 1'b0;
    unique case (op_q)
      OpSll: begin
        step_w   = {work_q[WIDTH-2:0], 1'b0};
        step_bit = work_q[WIDTH-1];
      end
      OpSrl: begin
        step_w   = {1'b0, work_q[WIDTH-1:1]};
        step_bit = work_q[0];
      end
      OpSra: begin
        step_w   = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        step_bit = work_q[0];
      end
      OpRol: begin
        step_w   = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        step_bit = work_q[WIDTH-1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      work_q      <= '0;
      op_q        <= 2'b00;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      shift_out_q <= '0;
      carry_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (bus.start) begin
            work_q  <= bus.alu_result;
            op_q    <= bus.shift_op;
            count_q <= bus.shamt;
            if (bus.shamt == '0) begin
              // Zero shift: pass the operand straight through, nothing shifted out.
              shift_out_q <= bus.alu_result;
              carry_q     <= 1'b0;
              state_q     <= StDone;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              state_q <= StShift;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        StShift: begin
          // start is ignored here; inputs may change freely while shifting.
          work_q  <= step_w;
          count_q <= count_q - 1'b1;
          if (count_q == SHAMT_W'(1)) begin
            shift_out_q <= step_w;
            carry_q     <= step_bit;
            state_q     <= StDone;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.shift_out = shift_out_q;
  assign bus.carry_out = carry_q;
  assign bus.zero      = (shift_out_q == '0);

endmodule

// File: tb/tb_alu_shift_stage.sv
// Scoreboard bench for alu_shift_stage: directed requests push hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_shift_stage;

  logic clk;
  logic rst;

  alu_shift_stage_if #(.WIDTH(16), .SHAMT_W(4)) bus ();

  alu_shift_stage #(.WIDTH(16), .SHAMT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] res;
    logic        carry;
    int          busy_cycles;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   busy_run = 0;
  logic [15:0] prev_out = 16'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: samples away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      busy_run = 0;
      prev_out = bus.shift_out;
    end else begin
      check("busy_and_done_exclusive", {31'd0, bus.busy & bus.done}, 32'd0);
      if (!bus.done)
        check("shift_out_stable", {16'd0, bus.shift_out}, {16'd0, prev_out});
      if (bus.busy) busy_run++;
      if (bus.done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no pending request");
        end else begin
          e = exp_q.pop_front();
          check("shift_out", {16'd0, bus.shift_out}, {16'd0, e.res});
          check("carry_out", {31'd0, bus.carry_out}, {31'd0, e.carry});
          check("zero", {31'd0, bus.zero}, {31'd0, (e.res == 16'h0)});
          check("busy_cycles", busy_run, e.busy_cycles);
        end
        busy_run = 0;
      end
      prev_out = bus.shift_out;
    end
  end

  task automatic push_exp(input logic [15:0] res, input logic carry, input int n);
    exp_t e;
    e.res = res;
    e.carry = carry;
    e.busy_cycles = n;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic [15:0] a, input logic [1:0] op, input logic [3:0] n);
    bus.alu_result = a;
    bus.shift_op   = op;
    bus.shamt      = n;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    end
  endtask

  // Single-cycle start pulse, then wait for completion and let the stage go idle.
  task automatic run(input string name, input logic [15:0] a, input logic [1:0] op,
                     input logic [3:0] n, input logic [15:0] res, input logic carry);
    push_exp(res, carry, int'(n));
    @(posedge clk); #1;
    drive(a, op, n);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    drive(16'hDEAD, 2'b11, 4'd7);
    wait_done(name);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    drive(16'h0, 2'b00, 4'd0);
    #12;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_shift_out", {16'd0, bus.shift_out}, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd1);
    check("rst_carry", {31'd0, bus.carry_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run("sll4", 16'h0001, 2'b00, 4'd4, 16'h0010, 1'b0);
    run("sra15", 16'h8000, 2'b10, 4'd15, 16'hFFFF, 1'b0);

    // Back-to-back: SRL 1 then ROL 1 with start held through done.
    push_exp(16'h4000, 1'b1, 1);
    push_exp(16'h0003, 1'b1, 1);
    @(posedge clk); #1;
    drive(16'h8001, 2'b01, 4'd1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    drive(16'h8001, 2'b11, 4'd1);
    @(posedge clk); #1;
    check("b2b_done_before_capture", {31'd0, bus.done}, 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("rol_b2b");

    run("zero_shamt", 16'h0000, 2'b00, 4'd0, 16'h0000, 1'b0);

    // Second start during SHIFT is ignored.
    push_exp(16'hFF00, 1'b1, 8);
    @(posedge clk); #1;
    drive(16'h01FF, 2'b00, 4'd8);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    drive(16'h1234, 2'b01, 4'd2);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("ignored_start");

    // Async reset mid-shift: no result expected for the discarded request.
    @(posedge clk); #1;
    drive(16'h00F0, 2'b00, 4'd8);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_shift_out", {16'd0, bus.shift_out}, 32'd0);
    check("midrst_zero", {31'd0, bus.zero}, 32'd1);
    check("midrst_carry", {31'd0, bus.carry_out}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run("rol3_after_rst", 16'hA5A5, 2'b11, 4'd3, 16'h2D2D, 1'b1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
